ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter with aging. Shares the single RAM port between NREQ cache requesters (icache/dcache of both cores) and sequences multi-word block transfers.
- Sits between cache-side request ports and the RAM model. Generates per-word addresses and applies the ramstate handshake (FREE/BUSY/ACCESS/ERROR).
- Coherence and snooping stay outside this block; requests arrive already coherence-resolved.

Parameters:
NREQ, 4, number of requesters (index 0 highest static tiebreak)
BURST_WORDS, 2, words per block transfer when req_burst=1 (power of 2, >=2)
AGE_LIMIT, 8, lost arbitrations before a requester is forced to top priority
WDOG_LIMIT, 255, cycles without ACCESS before abort (only with ARB_WDOG_EN)

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
req_ren  in  NREQ  read request per requester
req_wen  in  NREQ  write request per requester (wins over ren)
req_burst  in  NREQ  1 = BURST_WORDS-word block, 0 = single word
req_addr  in  NREQx32  word-aligned base address
req_store  in  NREQx32  write data for current word (requester updates per word_idx)
req_wait  out  NREQ  0 only in the cycle its word completes
req_err  out  NREQ  one-cycle pulse on transfer abort due to ERROR/watchdog
req_load  out  32  ramload broadcast
grant  out  NREQ  one-hot owner, 0 when idle
word_idx  out  log2(BURST_WORDS)  current word within the block
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
ramload  in  32  read data
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable

Behaviour:
- Reset: state IDLE, grant=0, req_wait all 1, req_err=0, word_idx=0, ramREN=ramWEN=0, ramaddr=ramstore=0, rr pointer=0, all age counters=0.
- FSM has two states: IDLE and XFER.
- IDLE:
  - Outputs RAM-idle.
  - If any (ren|wen) is set, pick a winner:
    - If any age counter >= AGE_LIMIT: lowest-index aged requester.
    - Otherwise: first active requester scanning from the rr pointer upward, with wrap.
  - Register grant, latch the burst length (1 or BURST_WORDS), word_idx=0, go to XFER next cycle.
  - Minimum latency: request in cycle t, ram enable asserted in cycle t+1.
- XFER, owner g:
  - ramaddr = req_addr[g] + (word_idx<<2), 32-bit wrap.
  - If wen[g]: ramWEN=1 and ramstore=req_store[g]. Otherwise ramREN=1.
  - req_wait[g] = (ramstate != ACCESS). req_load = ramload. All other req_wait stay 1.
  - On ACCESS:
    - Not the last word: word_idx++ and stay in XFER.
    - Last word: go to IDLE, rr pointer = g+1 mod NREQ, clear age[g].
    - Every other requester holding a request at grant-completion increments its age counter, saturating at AGE_LIMIT.
  - On ERROR: req_err[g]=1 for one cycle, req_wait[g] stays 1, go to IDLE, rr pointer = g+1. No age updates.
  - If the owner drops both ren and wen mid-transfer: abort to IDLE this cycle. RAM enables deassert combinationally, no err, rr pointer = g+1.
  - Direction switch mid-transfer: the current request type (ren/wen) is sampled every cycle.
- At least one IDLE cycle separates consecutive grants, including back-to-back requests from the same requester.
- A request raised during XFER by a non-owner waits; it is considered at the next IDLE.
- Reset mid-transfer: immediate return to reset values; the in-flight word is lost.

Optional Feature:
- Macro ARB_WDOG_EN.
- Defined: a cycle counter clears on entering XFER and on each ACCESS, and increments otherwise. On reaching WDOG_LIMIT: abort exactly as for ERROR (req_err pulse, go to IDLE).
- Undefined: no counter; XFER waits indefinitely for ACCESS/ERROR.

Test Plan:
- Single read: req_ren[1]=1, burst=0, addr=0x100, ACCESS after 2 BUSY cycles -> ramaddr=0x100 and ramREN=1 from cycle 1; req_wait[1]=0 in cycle 3 only; back to IDLE with grant=0.
- Burst write: req_wen[0], burst=1, addr=0x200, ACCESS every cycle -> ramaddr 0x200 then 0x204, ramWEN=1 both cycles, word_idx 0 then 1, then IDLE.
- Round-robin: all four requesters assert single reads continuously -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Aging: requester 3 competing with 0..2 under a starved-pointer pattern (rr forced past 3 each time) -> after 8 losses, requester 3 is granted next regardless of pointer.
- Error/abort: ERROR during word 0 of a burst -> req_err pulse 1 cycle, req_wait stays 1, next grant goes to g+1; separately, owner drops ren mid-burst -> ramREN=0 the same cycle, IDLE next cycle.
- With ARB_WDOG_EN and WDOG_LIMIT=4: ramstate held BUSY -> req_err after 4 cycles in XFER; without the macro, grant is held indefinitely.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin RAM port arbiter with aging and multi-word block sequencing.
// Optional transfer watchdog enabled by defining ARB_WDOG_EN.
module ram_port_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned BURST_WORDS = 2,
  parameter int unsigned AGE_LIMIT   = 8,
  parameter int unsigned WDOG_LIMIT  = 255
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NREQ-1:0]                req_ren,
  input  logic [NREQ-1:0]                req_wen,
  input  logic [NREQ-1:0]                req_burst,
  input  logic [NREQ-1:0][31:0]          req_addr,
  input  logic [NREQ-1:0][31:0]          req_store,
  output logic [NREQ-1:0]                req_wait,
  output logic [NREQ-1:0]                req_err,
  output logic [31:0]                    req_load,
  output logic [NREQ-1:0]                grant,
  output logic [$clog2(BURST_WORDS)-1:0] word_idx,
  input  logic [1:0]                     ramstate,
  input  logic [31:0]                    ramload,
  output logic [31:0]                    ramaddr,
  output logic [31:0]                    ramstore,
  output logic                           ramREN,
  output logic                           ramWEN
);

  localparam int unsigned IdxW = $clog2(BURST_WORDS);
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned AgeW = $clog2(AGE_LIMIT + 1);

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;

  typedef enum logic {StIdle, StXfer} state_e;

  state_e                      state_q;
  logic [NREQ-1:0]             grant_q;
  logic [PtrW-1:0]             owner_q;
  logic [PtrW-1:0]             rr_q;
  logic [IdxW-1:0]             word_q;
  logic                        burst_q;
  logic [NREQ-1:0][AgeW-1:0]   age_q;

  logic [NREQ-1:0] active;
  logic            xfer;
  logic            own_active;
  logic            own_wen;
  logic            ram_acc;
  logic            ram_err;
  logic            wdog_hit;
  logic            last_word;
  logic [PtrW-1:0] rr_next;
  logic [31:0]     own_addr;

  logic            aged_hit;
  logic [PtrW-1:0] aged_idx;
  logic            rr_hit;
  logic [PtrW-1:0] rr_idx;
  logic [PtrW-1:0] win_idx;
  int              j;

  assign active     = req_ren | req_wen;
  assign xfer       = (state_q == StXfer);
  assign own_active = active[owner_q];
  assign own_wen    = req_wen[owner_q];
  assign ram_acc    = (ramstate == RamAccess);
  assign ram_err    = (ramstate == RamError) | wdog_hit;
  assign last_word  = !burst_q || (word_q == IdxW'(BURST_WORDS - 1));
  assign rr_next    = PtrW'((int'(owner_q) + 1) % int'(NREQ));
  assign own_addr   = req_addr[owner_q] + (32'(word_q) << 2);

`ifdef ARB_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_LIMIT + 1);
  logic [WdogW-1:0] wdog_q;

  assign wdog_hit = xfer && (wdog_q == WdogW'(WDOG_LIMIT));

  // Held at zero while idle, so every transfer starts with a fresh count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog_q <= '0;
    end else if (!xfer || ram_acc) begin
      wdog_q <= '0;
    end else if (!wdog_hit) begin
      wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_hit          = 1'b0;
`endif

  // Winner selection: aged requesters first (lowest index), else round-robin from rr_q.
  always_comb begin
    aged_hit = 1'b0;
    aged_idx = '0;
    rr_hit   = 1'b0;
    rr_idx   = rr_q;
    j        = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!aged_hit && active[PtrW'(i)] && (age_q[PtrW'(i)] >= AgeW'(AGE_LIMIT))) begin
        aged_hit = 1'b1;
        aged_idx = PtrW'(i);
      end
    end
    for (int k = 0; k < int'(NREQ); k++) begin
      j = (int'(rr_q) + k) % int'(NREQ);
      if (!rr_hit && active[PtrW'(j)]) begin
        rr_hit = 1'b1;
        rr_idx = PtrW'(j);
      end
    end
    win_idx = aged_hit ? aged_idx : rr_idx;
  end

  // RAM side follows the owner's live request so a drop or direction change acts this cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_err  = '0;
    if (xfer) begin
      ramaddr = own_addr;
      if (own_wen) begin
        ramWEN   = 1'b1;
        ramstore = req_store[owner_q];
      end else if (own_active) begin
        ramREN = 1'b1;
      end
      if (own_active && ram_err) begin
        req_err[owner_q] = 1'b1;
      end else if (own_active && ram_acc) begin
        req_wait[owner_q] = 1'b0;
      end
    end
  end

  assign req_load = ramload;
  assign grant    = grant_q;
  assign word_idx = word_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      word_q  <= '0;
      burst_q <= 1'b0;
      age_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|active) begin
            state_q <= StXfer;
            owner_q <= win_idx;
            grant_q <= NREQ'(1) << win_idx;
            burst_q <= req_burst[win_idx];
            word_q  <= '0;
          end
        end
        StXfer: begin
          if (!own_active || ram_err) begin
            state_q <= StIdle;
            grant_q <= '0;
            word_q  <= '0;
            rr_q    <= rr_next;
          end else if (ram_acc) begin
            if (last_word) begin
              state_q <= StIdle;
              grant_q <= '0;
              word_q  <= '0;
              rr_q    <= rr_next;
              for (int i = 0; i < int'(NREQ); i++) begin
                if (PtrW'(i) == owner_q) begin
                  age_q[PtrW'(i)] <= '0;
                end else if (active[PtrW'(i)] && (age_q[PtrW'(i)] < AgeW'(AGE_LIMIT))) begin
                  age_q[PtrW'(i)] <= age_q[PtrW'(i)] + 1'b1;
                end
              end
            end else begin
              word_q <= word_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter: reset, single/burst transfers, round-robin,
// aging, error/drop aborts and watchdog behaviour.
module tb_ram_port_arbiter;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [3:0]       req_ren;
  logic [3:0]       req_wen;
  logic [3:0]       req_burst;
  logic [3:0][31:0] req_addr;
  logic [3:0][31:0] req_store;
  logic [3:0]       req_wait;
  logic [3:0]       req_err;
  logic [31:0]      req_load;
  logic [3:0]       grant;
  logic [0:0]       word_idx;
  logic [1:0]       ramstate;
  logic [31:0]      ramload;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic             ramREN;
  logic             ramWEN;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(
    .NREQ(4), .BURST_WORDS(2), .AGE_LIMIT(8), .WDOG_LIMIT(4)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_burst(req_burst),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_err(req_err), .req_load(req_load),
    .grant(grant), .word_idx(word_idx),
    .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    req_ren = '0; req_wen = '0; req_burst = '0;
    req_addr = '0; req_store = '0;
    ramstate = Free; ramload = '0;
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({grant, req_wait, req_err, word_idx, ramREN, ramWEN} !== {4'h0, 4'hF, 4'h0, 1'b0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_ctl: got %b want %b",
               {grant, req_wait, req_err, word_idx, ramREN, ramWEN}, 15'b0000_1111_0000_0_00);
    end
    n_cmp++;
    if ({ramaddr, ramstore} !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore});
    end
    nRST = 1'b1;
    req_ren = 4'b0001; ramstate = Busy;
    tick(); tick();
    n_cmp++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL midxfer_grant: got %b want 0001", grant);
    end
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({grant, ramREN, req_wait} !== {4'h0, 1'b0, 4'hF}) begin
      n_bad++;
      $display("FAIL midxfer_reset: got %b want 000001111", {grant, ramREN, req_wait});
    end
    nRST = 1'b1;
    req_ren = '0;
  endtask

  task automatic test_single_read;
    do_reset();
    req_ren = 4'b0010; req_addr[1] = 32'h100; ramstate = Busy; ramload = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({grant, ramREN, ramWEN} !== 6'b0) begin
      n_bad++;
      $display("FAIL rd_idle: got %b want 000000", {grant, ramREN, ramWEN});
    end
    tick();
    n_cmp++;
    if ({grant, ramREN, req_wait} !== {4'b0010, 1'b1, 4'hF} || ramaddr !== 32'h100) begin
      n_bad++;
      $display("FAIL rd_c1: got %b/%h want 001011111/00000100", {grant, ramREN, req_wait}, ramaddr);
    end
    tick();
    n_cmp++;
    if ({ramREN, req_wait} !== 5'b11111) begin
      n_bad++;
      $display("FAIL rd_c2: got %b want 11111", {ramREN, req_wait});
    end
    tick();
    ramstate = Access;
    #1;
    n_cmp++;
    if (req_wait !== 4'b1101 || req_load !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rd_c3: got %b/%h want 1101/deadbeef", req_wait, req_load);
    end
    tick();
    req_ren = '0; ramstate = Free;
    #1;
    n_cmp++;
    if ({grant, ramREN, req_wait} !== {4'h0, 1'b0, 4'hF}) begin
      n_bad++;
      $display("FAIL rd_done: got %b want 000001111", {grant, ramREN, req_wait});
    end
  endtask

  task automatic test_burst_write;
    do_reset();
    req_wen = 4'b0001; req_ren = 4'b0001; req_burst = 4'b0001;
    req_addr[0] = 32'h200; req_store[0] = 32'hA0A0_0000; ramstate = Access;
    tick();
    n_cmp++;
    if ({ramWEN, ramREN, word_idx, req_wait} !== {1'b1, 1'b0, 1'b0, 4'b1110}
        || ramaddr !== 32'h200 || ramstore !== 32'hA0A0_0000) begin
      n_bad++;
      $display("FAIL wr_w0: got %b/%h/%h want 1001110/00000200/a0a00000",
               {ramWEN, ramREN, word_idx, req_wait}, ramaddr, ramstore);
    end
    tick();
    req_store[0] = 32'hA0A0_0004;
    #1;
    n_cmp++;
    if ({ramWEN, word_idx, grant} !== {1'b1, 1'b1, 4'b0001}
        || ramaddr !== 32'h204 || ramstore !== 32'hA0A0_0004) begin
      n_bad++;
      $display("FAIL wr_w1: got %b/%h/%h want 110001/00000204/a0a00004",
               {ramWEN, word_idx, grant}, ramaddr, ramstore);
    end
    tick();
    req_wen = '0; req_ren = '0;
    #1;
    n_cmp++;
    if ({grant, word_idx, ramWEN} !== 6'b0) begin
      n_bad++;
      $display("FAIL wr_done: got %b want 000000", {grant, word_idx, ramWEN});
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    req_ren = 4'hF; ramstate = Access;
    #1;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (grant !== exp_g[c]) begin
        n_bad++;
        $display("FAIL rr_cycle%0d: got %b want %b", c, grant, exp_g[c]);
      end
      tick();
    end
    req_ren = '0;
    tick();
  endtask

  task automatic test_aging;
    int         win   [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 3};
    logic       idle3 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    logic       xfer3 [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [3:0] exp_g;
    do_reset();
    req_ren = 4'b0011; ramstate = Access;
    for (int r = 0; r < 10; r++) begin
      req_ren[3] = idle3[r];
      #1;
      n_cmp++;
      if (grant !== 4'h0) begin
        n_bad++;
        $display("FAIL age_idle%0d: got %b want 0000", r, grant);
      end
      tick();
      req_ren[3] = xfer3[r];
      exp_g = 4'b0001 << win[r];
      #1;
      n_cmp++;
      if (grant !== exp_g) begin
        n_bad++;
        $display("FAIL age_grant%0d: got %b want %b", r, grant, exp_g);
      end
      tick();
    end
    req_ren = '0;
    tick();
  endtask

  task automatic test_error_abort;
    do_reset();
    req_ren = 4'b1100; req_burst = 4'b0100; req_addr[2] = 32'h300; ramstate = Busy;
    tick();
    ramstate = Error;
    #1;
    n_cmp++;
    if ({grant, req_err, req_wait} !== {4'b0100, 4'b0100, 4'hF} || ramaddr !== 32'h300) begin
      n_bad++;
      $display("FAIL err_pulse: got %b/%h want 010001001111/00000300",
               {grant, req_err, req_wait}, ramaddr);
    end
    tick();
    ramstate = Access;
    #1;
    n_cmp++;
    if ({grant, req_err} !== 8'h00) begin
      n_bad++;
      $display("FAIL err_idle: got %b want 00000000", {grant, req_err});
    end
    tick();
    n_cmp++;
    if (grant !== 4'b1000) begin
      n_bad++;
      $display("FAIL err_next: got %b want 1000", grant);
    end
    tick();
    req_ren = '0;
    tick();
  endtask

  task automatic test_drop_abort;
    do_reset();
    req_ren = 4'b0010; req_burst = 4'b0010; req_addr[1] = 32'h40; ramstate = Access;
    tick();
    tick();
    n_cmp++;
    if (word_idx !== 1'b1 || ramaddr !== 32'h44 || ramREN !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_w1: got %b/%h/%b want 1/00000044/1", word_idx, ramaddr, ramREN);
    end
    req_ren = '0;
    #1;
    n_cmp++;
    if ({ramREN, req_err, req_wait} !== {1'b0, 4'h0, 4'hF}) begin
      n_bad++;
      $display("FAIL drop_same: got %b want 000001111", {ramREN, req_err, req_wait});
    end
    tick();
    req_ren = 4'b0101;
    #1;
    n_cmp++;
    if (grant !== 4'h0) begin
      n_bad++;
      $display("FAIL drop_idle: got %b want 0000", grant);
    end
    tick();
    n_cmp++;
    if (grant !== 4'b0100) begin
      n_bad++;
      $display("FAIL drop_rr: got %b want 0100", grant);
    end
    req_ren = '0;
    tick();
  endtask

  task automatic test_watchdog;
    logic bad;
    do_reset();
    req_ren = 4'b0001; ramstate = Busy;
    tick();
`ifdef ARB_WDOG_EN
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (grant !== 4'b0001 || req_err !== ((c == 4) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL wdog_c%0d: got %b/%b want 0001/%b", c, grant, req_err,
                 (c == 4) ? 4'b0001 : 4'b0000);
      end
      if (c == 4) req_ren = '0;
      tick();
    end
    n_cmp++;
    if (grant !== 4'h0) begin
      n_bad++;
      $display("FAIL wdog_idle: got %b want 0000", grant);
    end
`else
    bad = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (grant !== 4'b0001 || req_err !== 4'h0 || ramREN !== 1'b1) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL wdog_hold: got grant %b err %b want 0001/0000 for 300 cycles",
               grant, req_err);
    end
    ramstate = Access;
    #1;
    n_cmp++;
    if (req_wait !== 4'b1110) begin
      n_bad++;
      $display("FAIL wdog_late_access: got %b want 1110", req_wait);
    end
    tick();
    req_ren = '0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_round_robin();
    test_aging();
    test_error_abort();
    test_drop_abort();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
